// File: rtl/rsa_mod_in_deserializer.sv
// Collects 3*WORDS stream words into one {msg, key, modulus} operand struct for the RSA core.
// o_data packs msg in the top MOD_WIDTH bits, then key, then modulus in the low bits.
module rsa_mod_in_deserializer #(
  parameter int unsigned MOD_WIDTH = 256,
  parameter int unsigned INT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [INT_WIDTH-1:0]   i_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [3*MOD_WIDTH-1:0] o_data
);

  localparam int unsigned Words    = MOD_WIDTH / INT_WIDTH;
  localparam int unsigned WordIdxW = (Words > 1) ? $clog2(Words) : 1;

  typedef enum logic [0:0] {StCollect, StOut} state_e;

  state_e                 state_q, state_d;
  logic [WordIdxW-1:0]    word_idx_q, word_idx_d;
  logic [1:0]             field_idx_q, field_idx_d;
  logic                   i_ready_q, i_ready_d;
  logic                   o_valid_q, o_valid_d;
  logic [3*MOD_WIDTH-1:0] data_q, data_d;

  logic word_accept;
  logic last_in_field;
  logic last_word;

  // i_ready_q is only ever set while collecting, so it alone qualifies a word transfer.
  assign word_accept   = i_valid && i_ready_q;
  assign last_in_field = (word_idx_q == WordIdxW'(Words - 1));
  assign last_word     = last_in_field && (field_idx_q == 2'd2);

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    field_idx_d = field_idx_q;
    i_ready_d   = i_ready_q;
    o_valid_d   = o_valid_q;
    data_d      = data_q;

    unique case (state_q)
      StCollect: begin
        i_ready_d = 1'b1;
        o_valid_d = 1'b0;
        if (word_accept) begin
          // Field 0 (msg) occupies the top slice, field 2 (modulus) the bottom.
          for (int unsigned f = 0; f < 3; f++) begin
            for (int unsigned w = 0; w < Words; w++) begin
              if (field_idx_q == 2'(f) && word_idx_q == WordIdxW'(w)) begin
                data_d[(2 - f) * MOD_WIDTH + w * INT_WIDTH +: INT_WIDTH] = i_data;
              end
            end
          end
          if (last_word) begin
            state_d     = StOut;
            word_idx_d  = '0;
            field_idx_d = '0;
            i_ready_d   = 1'b0;
            o_valid_d   = 1'b1;
          end else if (last_in_field) begin
            word_idx_d  = '0;
            field_idx_d = field_idx_q + 2'd1;
          end else begin
            word_idx_d  = word_idx_q + WordIdxW'(1);
          end
        end
      end
      StOut: begin
        i_ready_d = 1'b0;
        o_valid_d = 1'b1;
        if (o_valid_q && o_ready) begin
          state_d   = StCollect;
          o_valid_d = 1'b0;
          i_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      word_idx_q  <= '0;
      field_idx_q <= '0;
      i_ready_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      field_idx_q <= field_idx_d;
      i_ready_q   <= i_ready_d;
      o_valid_q   <= o_valid_d;
      data_q      <= data_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = data_q;

endmodule
